// File: rtl/param_register.sv
// General-purpose holding register with load enable, synchronous clear,
// per-bit write mask, last-distinct-value history, change flag and even parity.
module param_register #(
  parameter int              SIZE        = 4,
  parameter logic [SIZE-1:0] RESET_VALUE = {SIZE{1'b0}},
  parameter bit              USE_MASK    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [SIZE-1:0] wmask,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] q_prev,
  output logic            changed,
  output logic            parity
);

  function automatic logic even_parity(input logic [SIZE-1:0] v);
    return ^v;
  endfunction

  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] prev_q, prev_d;
  logic            changed_q, changed_d;

  // Next-state selection: clear beats load, load beats hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VALUE;
    end else if (en) begin
      // AND-OR merge keeps unknown data on unwritten bits out of q.
      if (USE_MASK) begin
        q_d = (d & wmask) | (q_q & ~wmask);
      end else begin
        q_d = d;
      end
    end else begin
      q_d = q_q;
    end
  end

  // History only advances when q actually takes a new value.
  always_comb begin
    changed_d = (q_d != q_q);
    prev_d    = prev_q;
    if (changed_d) begin
      prev_d = q_q;
    end else begin
      prev_d = prev_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= RESET_VALUE;
      prev_q    <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign q_prev  = prev_q;
  assign changed = changed_q;
  assign parity  = even_parity(q_q);

endmodule

// File: tb/tb_param_register.sv
// Directed self-checking bench for param_register: one masked 4-bit instance
// and one unmasked 8-bit instance with a non-zero reset value.
module tb_param_register;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] wmask = 4'hF;
  logic [3:0] d = 4'h0;
  logic [3:0] q, q_prev;
  logic       changed, parity;

  logic [7:0] wmask2 = 8'h00;
  logic [7:0] d2 = 8'hA4;
  logic [7:0] q2, q_prev2;
  logic       changed2, parity2;

  int n_cmp = 0;
  int n_bad = 0;

  param_register #(.SIZE(4), .RESET_VALUE(4'h0), .USE_MASK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wmask(wmask), .d(d),
    .q(q), .q_prev(q_prev), .changed(changed), .parity(parity)
  );

  param_register #(.SIZE(8), .RESET_VALUE(8'hA4), .USE_MASK(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wmask(wmask2), .d(d2),
    .q(q2), .q_prev(q_prev2), .changed(changed2), .parity(parity2)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    d = 4'hA;
    #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_q got %h exp %h", q, 4'h0); end
    n_cmp++; if (q_prev !== 4'h0) begin n_bad++; $display("FAIL reset_prev got %h exp %h", q_prev, 4'h0); end
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed got %b exp 0", changed); end
    n_cmp++; if (parity !== 1'b0) begin n_bad++; $display("FAIL reset_parity got %b exp 0", parity); end
    n_cmp++; if (q2 !== 8'hA4) begin n_bad++; $display("FAIL reset_q2 got %h exp a4", q2); end
    n_cmp++; if (parity2 !== 1'b1) begin n_bad++; $display("FAIL reset_parity2 got %b exp 1", parity2); end
    clk_run = 1'b1;
    step();
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_hold_q got %h exp 0", q); end
    rst_n = 1'b1;
    d = 4'h0;
  endtask

  task automatic test_count();
    logic [3:0] e;
    en = 1'b1; wmask = 4'hF; clr = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      e = k[3:0];
      d = e;
      step();
      n_cmp++; if (q !== e) begin n_bad++; $display("FAIL count_q k=%0d got %h exp %h", k, q, e); end
      n_cmp++; if (parity !== ^e) begin n_bad++; $display("FAIL count_parity k=%0d got %b exp %b", k, parity, ^e); end
      if (k > 0) begin
        n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL count_changed k=%0d got %b exp 1", k, changed); end
        n_cmp++; if (q_prev !== e - 4'd1) begin n_bad++; $display("FAIL count_prev k=%0d got %h exp %h", k, q_prev, e - 4'd1); end
      end else begin
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL count_changed0 got %b exp 0", changed); end
      end
      step();
      n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL count_settle k=%0d got %b exp 0", k, changed); end
      n_cmp++; if (q !== e) begin n_bad++; $display("FAIL count_settle_q k=%0d got %h exp %h", k, q, e); end
    end
    d = 4'h3; step();
    n_cmp++; if (parity !== 1'b0) begin n_bad++; $display("FAIL parity_3 got %b exp 0", parity); end
    d = 4'h7; step();
    n_cmp++; if (parity !== 1'b1) begin n_bad++; $display("FAIL parity_7 got %b exp 1", parity); end
  endtask

  task automatic test_hold();
    en = 1'b1; wmask = 4'hF;
    d = 4'h2; step();
    d = 4'h5; step();
    en = 1'b0; d = 4'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL hold_q i=%0d got %h exp 5", i, q); end
      n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL hold_changed i=%0d got %b exp 0", i, changed); end
      n_cmp++; if (q_prev !== 4'h2) begin n_bad++; $display("FAIL hold_prev i=%0d got %h exp 2", i, q_prev); end
    end
  endtask

  task automatic test_mask();
    en = 1'b1; wmask = 4'b0011; d = 4'hA;
    step();
    n_cmp++; if (q !== 4'h6) begin n_bad++; $display("FAIL mask_q got %h exp 6", q); end
    n_cmp++; if (q_prev !== 4'h5) begin n_bad++; $display("FAIL mask_prev got %h exp 5", q_prev); end
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL mask_changed got %b exp 1", changed); end
    en = 1'b0; step();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL mask_pulse got %b exp 0", changed); end
    n_cmp++; if (q !== 4'h6) begin n_bad++; $display("FAIL mask_hold got %h exp 6", q); end
  endtask

  task automatic test_clear();
    en = 1'b1; wmask = 4'hF; d = 4'h9; step();
    clr = 1'b1; d = 4'hF; step();
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL clr_q got %h exp 0", q); end
    n_cmp++; if (q_prev !== 4'h9) begin n_bad++; $display("FAIL clr_prev got %h exp 9", q_prev); end
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL clr_changed got %b exp 1", changed); end
    step();
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL clr_again_changed got %b exp 0", changed); end
    n_cmp++; if (q_prev !== 4'h9) begin n_bad++; $display("FAIL clr_again_prev got %h exp 9", q_prev); end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; wmask = 4'hF; d = 4'h7; step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL arst_q got %h exp 0", q); end
    n_cmp++; if (q_prev !== 4'h0) begin n_bad++; $display("FAIL arst_prev got %h exp 0", q_prev); end
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL arst_changed got %b exp 0", changed); end
    n_cmp++; if (parity !== 1'b0) begin n_bad++; $display("FAIL arst_parity got %b exp 0", parity); end
    d = 4'h3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (q !== 4'h3) begin n_bad++; $display("FAIL arst_release_q got %h exp 3", q); end
    n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL arst_release_changed got %b exp 1", changed); end
    n_cmp++; if (q_prev !== 4'h0) begin n_bad++; $display("FAIL arst_release_prev got %h exp 0", q_prev); end
  endtask

  task automatic test_x_isolation();
    en = 1'b1; wmask = 4'b1100; d = 4'b01xx;
    step();
    n_cmp++; if (q !== 4'h7) begin n_bad++; $display("FAIL xmask_q got %b exp 0111", q); end
    en = 1'b0; d = 4'bxxxx;
    step();
    n_cmp++; if (q !== 4'h7) begin n_bad++; $display("FAIL xhold_q got %b exp 0111", q); end
    n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL xhold_changed got %b exp 0", changed); end
    d = 4'h0;
  endtask

  task automatic test_nomask();
    en = 1'b1; clr = 1'b0; wmask2 = 8'h00; d2 = 8'h3C;
    step();
    n_cmp++; if (q2 !== 8'h3C) begin n_bad++; $display("FAIL nomask_q got %h exp 3c", q2); end
    n_cmp++; if (q_prev2 !== 8'hA4) begin n_bad++; $display("FAIL nomask_prev got %h exp a4", q_prev2); end
    n_cmp++; if (changed2 !== 1'b1) begin n_bad++; $display("FAIL nomask_changed got %b exp 1", changed2); end
    n_cmp++; if (parity2 !== 1'b0) begin n_bad++; $display("FAIL nomask_parity got %b exp 0", parity2); end
    clr = 1'b1;
    step();
    n_cmp++; if (q2 !== 8'hA4) begin n_bad++; $display("FAIL nomask_clr_q got %h exp a4", q2); end
    n_cmp++; if (q_prev2 !== 8'h3C) begin n_bad++; $display("FAIL nomask_clr_prev got %h exp 3c", q_prev2); end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_mask();
    test_clear();
    test_async_reset();
    test_x_isolation();
    test_nomask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
